// File: rtl/ov5640_capture.sv
// OV5640 DVP capture: registers the sensor bus once, skips the first frames
// after configuration, assembles RGB565 pixels from byte pairs and tracks
// pixel coordinates plus sticky line/frame length errors.
module ov5640_capture #(
   parameter int FRAME_SKIP = 10,
   parameter int H_PIX      = 640,
   parameter int V_LINES    = 480
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_done,
   input  logic        cam_vsync,
   input  logic        cam_href,
   input  logic [7:0]  cam_data,
   output logic [15:0] pix_data,
   output logic        pix_valid,
   output logic [10:0] pix_x,
   output logic [10:0] pix_y,
   output logic        frame_start,
   output logic        line_err,
   output logic        frame_err
);

   typedef enum logic [1:0] {IDLE, SKIP, ACTIVE} state_t;

   // FRAME_SKIP of 0 behaves like 1: leave SKIP on the first vsync edge.
   localparam logic [3:0]  SKIP_LAST = (FRAME_SKIP == 0) ? 4'd0 : 4'(FRAME_SKIP - 1);
   localparam logic [10:0] H_PIX_W   = 11'(H_PIX);
   localparam logic [10:0] V_LINES_W = 11'(V_LINES);
   localparam logic [10:0] IDX_MAX   = 11'h7FF;

   state_t      state_reg, state_next;
   logic        s1_vsync_reg, s1_href_reg;
   logic [7:0]  s1_data_reg;
   logic        vsync_d_reg, href_d_reg;
   logic [3:0]  skip_cnt_reg;
   logic        phase_reg;
   logic [7:0]  high_reg;
   logic [10:0] x_cnt_reg;
   logic [10:0] pix_x_reg, pix_y_reg;
   logic [15:0] pix_data_reg;
   logic        pix_valid_reg, frame_start_reg;
   logic        line_err_reg, frame_err_reg;

   logic        vsync_rise, href_fall, skip_done;
   logic        fs_event, pix_en, line_chk, frame_chk, clear_err;

   // Edges are taken on the registered copy against its own previous value.
   assign vsync_rise = s1_vsync_reg & ~vsync_d_reg;
   assign href_fall  = ~s1_href_reg & href_d_reg;
   assign skip_done  = (skip_cnt_reg == SKIP_LAST);

   // Input stage S1 plus one-cycle history for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vsync_reg <= 1'b0;
         s1_href_reg  <= 1'b0;
         s1_data_reg  <= 8'h00;
         vsync_d_reg  <= 1'b0;
         href_d_reg   <= 1'b0;
      end else begin
         s1_vsync_reg <= cam_vsync;
         s1_href_reg  <= cam_href;
         s1_data_reg  <= cam_data;
         vsync_d_reg  <= s1_vsync_reg;
         href_d_reg   <= s1_href_reg;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // FSM next-state logic; losing cfg_done always falls back to IDLE.
   always_comb begin
      state_next = state_reg;
      if (!cfg_done) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE:    state_next = SKIP;
            SKIP:    if (vsync_rise && skip_done) state_next = ACTIVE;
            ACTIVE:  state_next = ACTIVE;
            default: state_next = IDLE;
         endcase
      end
   end

   // FSM output decode: which datapath actions are enabled this cycle.
   always_comb begin
      fs_event  = 1'b0;
      pix_en    = 1'b0;
      line_chk  = 1'b0;
      frame_chk = 1'b0;
      clear_err = 1'b0;
      case (state_reg)
         IDLE:   clear_err = cfg_done;
         SKIP:   fs_event  = cfg_done & vsync_rise & skip_done;
         ACTIVE: begin
            fs_event  = cfg_done & vsync_rise;
            pix_en    = cfg_done;
            line_chk  = cfg_done;
            frame_chk = cfg_done;
         end
         default: ;
      endcase
   end

   // Skipped-frame counter, only alive while in SKIP with configuration held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skip_cnt_reg <= 4'd0;
      end else if (state_reg != SKIP || !cfg_done) begin
         skip_cnt_reg <= 4'd0;
      end else if (vsync_rise && !skip_done) begin
         skip_cnt_reg <= skip_cnt_reg + 4'd1;
      end
   end

   // Byte pairing, pixel output and coordinate tracking; a frame boundary
   // wins over line activity, and a coincident byte opens the new frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_reg       <= 1'b0;
         high_reg        <= 8'h00;
         x_cnt_reg       <= 11'd0;
         pix_x_reg       <= 11'd0;
         pix_y_reg       <= 11'd0;
         pix_data_reg    <= 16'h0000;
         pix_valid_reg   <= 1'b0;
         frame_start_reg <= 1'b0;
      end else begin
         pix_valid_reg   <= 1'b0;
         frame_start_reg <= fs_event;
         if (vsync_rise) begin
            phase_reg <= s1_href_reg;
            if (s1_href_reg) high_reg <= s1_data_reg;
            x_cnt_reg <= 11'd0;
            pix_x_reg <= 11'd0;
            pix_y_reg <= 11'd0;
         end else if (s1_href_reg) begin
            if (!phase_reg) begin
               high_reg  <= s1_data_reg;
               phase_reg <= 1'b1;
            end else begin
               phase_reg <= 1'b0;
               if (x_cnt_reg != IDX_MAX) x_cnt_reg <= x_cnt_reg + 11'd1;
               if (pix_en) begin
                  pix_valid_reg <= 1'b1;
                  pix_data_reg  <= {high_reg, s1_data_reg};
                  pix_x_reg     <= x_cnt_reg;
               end
            end
         end else begin
            // A pending odd byte is simply dropped here.
            phase_reg <= 1'b0;
            if (href_fall) begin
               x_cnt_reg <= 11'd0;
               pix_x_reg <= 11'd0;
               if (x_cnt_reg != 11'd0 && pix_y_reg != IDX_MAX)
                  pix_y_reg <= pix_y_reg + 11'd1;
            end
         end
      end
   end

   // Sticky length errors, cleared only when a new configuration is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_err_reg  <= 1'b0;
         frame_err_reg <= 1'b0;
      end else if (clear_err) begin
         line_err_reg  <= 1'b0;
         frame_err_reg <= 1'b0;
      end else begin
         if (frame_chk && vsync_rise && pix_y_reg != V_LINES_W)
            frame_err_reg <= 1'b1;
         if (line_chk && !vsync_rise && href_fall &&
             (x_cnt_reg != H_PIX_W || phase_reg))
            line_err_reg <= 1'b1;
      end
   end

   assign pix_data    = pix_data_reg;
   assign pix_valid   = pix_valid_reg;
   assign pix_x       = pix_x_reg;
   assign pix_y       = pix_y_reg;
   assign frame_start = frame_start_reg;
   assign line_err    = line_err_reg;
   assign frame_err   = frame_err_reg;

endmodule

// File: tb/tb_ov5640_capture.sv
// Directed bench for ov5640_capture with small frame geometry
// (FRAME_SKIP=2, H_PIX=4, V_LINES=2).
module tb_ov5640_capture;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_done;
   logic        cam_vsync;
   logic        cam_href;
   logic [7:0]  cam_data;
   logic [15:0] pix_data;
   logic        pix_valid;
   logic [10:0] pix_x;
   logic [10:0] pix_y;
   logic        frame_start;
   logic        line_err;
   logic        frame_err;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int fs_cnt  = 0;
   int lcyc [16];

   logic [15:0] pd_q [$];
   int          px_q [$];
   int          py_q [$];
   int          pc_q [$];

   ov5640_capture #(.FRAME_SKIP(2), .H_PIX(4), .V_LINES(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_done    (cfg_done),
      .cam_vsync   (cam_vsync),
      .cam_href    (cam_href),
      .cam_data    (cam_data),
      .pix_data    (pix_data),
      .pix_valid   (pix_valid),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .frame_start (frame_start),
      .line_err    (line_err),
      .frame_err   (frame_err)
   );

   always #5 clk = ~clk;

   // Cycle counter used for latency measurement.
   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: record every pixel and count frame_start pulses.
   always @(negedge clk) begin
      if (pix_valid) begin
         pd_q.push_back(pix_data);
         px_q.push_back(int'(pix_x));
         py_q.push_back(int'(pix_y));
         pc_q.push_back(cyc);
      end
      if (frame_start) fs_cnt <= fs_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("[TB] ok %s = %0h", tag, got);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      cam_href = 1'b1;
      cam_data = b;
      @(negedge clk);
   endtask

   // n pixels whose bytes are base, base+1, base+2, ...
   task automatic send_pixels(input int n, input logic [7:0] base);
      for (int i = 0; i < n; i++) begin
         send_byte(base + 8'(2 * i));
         lcyc[i] = cyc;
         send_byte(base + 8'(2 * i + 1));
      end
   endtask

   task automatic end_line();
      cam_href = 1'b0;
      cam_data = 8'h00;
      repeat (4) @(negedge clk);
   endtask

   task automatic vsync_pulse();
      cam_vsync = 1'b1;
      repeat (3) @(negedge clk);
      cam_vsync = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic check_all_zero(input string pfx);
      check({pfx, "_pix_data"},    32'(pix_data), 32'h0);
      check({pfx, "_pix_valid"},   32'(pix_valid), 32'h0);
      check({pfx, "_pix_x"},       32'(pix_x), 32'h0);
      check({pfx, "_pix_y"},       32'(pix_y), 32'h0);
      check({pfx, "_frame_start"}, 32'(frame_start), 32'h0);
      check({pfx, "_line_err"},    32'(line_err), 32'h0);
      check({pfx, "_frame_err"},   32'(frame_err), 32'h0);
   endtask

   initial begin
      int pb;
      int fb;
      rst       = 1'b1;
      cfg_done  = 1'b0;
      cam_vsync = 1'b0;
      cam_href  = 1'b0;
      cam_data  = 8'h00;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Frame skipping: first vsync skipped, line inside it produces nothing.
      cfg_done = 1'b1;
      repeat (2) @(negedge clk);
      pb = pd_q.size();
      fb = fs_cnt;
      vsync_pulse();
      check("skip_fs_after_v1", 32'(fs_cnt - fb), 32'd0);
      send_pixels(4, 8'h20);
      end_line();
      check("skip_no_pixels", 32'(pd_q.size() - pb), 32'd0);
      vsync_pulse();
      check("fs_after_v2", 32'(fs_cnt - fb), 32'd1);
      check("pix_y_frame0", 32'(pix_y), 32'd0);

      // Line 1: four pixels, first two are F800 and 07E0.
      pb = pd_q.size();
      send_byte(8'hF8); lcyc[0] = cyc; send_byte(8'h00);
      send_byte(8'h07); lcyc[1] = cyc; send_byte(8'hE0);
      send_byte(8'h00); send_byte(8'h1F);
      send_byte(8'hFF); send_byte(8'hFF);
      end_line();
      check("l1_count", 32'(pd_q.size() - pb), 32'd4);
      if (pd_q.size() - pb >= 4) begin
         check("l1_p0_data", 32'(pd_q[pb]),     32'hF800);
         check("l1_p0_x",    32'(px_q[pb]),     32'd0);
         check("l1_p0_lat",  32'(pc_q[pb] - lcyc[0]), 32'd2);
         check("l1_p1_data", 32'(pd_q[pb + 1]), 32'h07E0);
         check("l1_p1_x",    32'(px_q[pb + 1]), 32'd1);
         check("l1_p1_lat",  32'(pc_q[pb + 1] - lcyc[1]), 32'd2);
         check("l1_p3_data", 32'(pd_q[pb + 3]), 32'hFFFF);
         check("l1_p3_y",    32'(py_q[pb + 3]), 32'd0);
      end
      check("l1_line_err", 32'(line_err), 32'd0);
      check("l1_pix_y",    32'(pix_y), 32'd1);
      check("l1_pix_x_clr", 32'(pix_x), 32'd0);

      // Line 2: three pixels, short line.
      pb = pd_q.size();
      send_pixels(3, 8'h12);
      end_line();
      check("l2_count", 32'(pd_q.size() - pb), 32'd3);
      if (pd_q.size() - pb >= 3) begin
         check("l2_p2_data", 32'(pd_q[pb + 2]), 32'h1617);
         check("l2_p2_x",    32'(px_q[pb + 2]), 32'd2);
         check("l2_p0_y",    32'(py_q[pb]),     32'd1);
      end
      check("l2_line_err", 32'(line_err), 32'd1);
      check("l2_pix_y",    32'(pix_y), 32'd2);

      // Frame of exactly V_LINES lines ends: no frame error.
      vsync_pulse();
      check("fs_after_v3", 32'(fs_cnt - fb), 32'd2);
      check("f1_frame_err", 32'(frame_err), 32'd0);
      check("f2_pix_y_zero", 32'(pix_y), 32'd0);

      // Frame of three lines: frame error on the next vsync.
      for (int l = 0; l < 3; l++) begin
         send_pixels(4, 8'h40);
         end_line();
      end
      check("f2_pix_y", 32'(pix_y), 32'd3);
      vsync_pulse();
      check("f2_frame_err", 32'(frame_err), 32'd1);

      // Drop cfg_done just before a pixel would come out.
      pb = pd_q.size();
      send_byte(8'hAA);
      send_byte(8'hBB);
      cfg_done = 1'b0;
      send_byte(8'hCC);
      check("drop_pix_valid", 32'(pix_valid), 32'd0);
      send_byte(8'hDD);
      end_line();
      check("drop_no_pixels", 32'(pd_q.size() - pb), 32'd0);
      check("drop_pix_data_hold", 32'(pix_data), 32'h4647);

      // Re-raising cfg_done passes IDLE -> SKIP and clears sticky errors.
      cfg_done = 1'b1;
      repeat (3) @(negedge clk);
      check("recfg_line_err", 32'(line_err), 32'd0);
      check("recfg_frame_err", 32'(frame_err), 32'd0);
      fb = fs_cnt;
      vsync_pulse();
      vsync_pulse();
      check("recfg_fs", 32'(fs_cnt - fb), 32'd1);

      // Seven-byte line: three pixels, odd byte dropped, line error.
      pb = pd_q.size();
      send_pixels(3, 8'h60);
      send_byte(8'h66);
      end_line();
      check("odd_count", 32'(pd_q.size() - pb), 32'd3);
      check("odd_pix_data", 32'(pix_data), 32'h6465);
      check("odd_line_err", 32'(line_err), 32'd1);

      // Reset in the middle of a flowing line.
      send_pixels(2, 8'h70);
      send_byte(8'h74);
      rst = 1'b1;
      #1;
      check_all_zero("midrst");
      cam_href = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      pb = pd_q.size();
      fb = fs_cnt;
      vsync_pulse();
      send_pixels(2, 8'h50);
      end_line();
      check("rst_skip_no_pixels", 32'(pd_q.size() - pb), 32'd0);
      check("rst_skip_no_fs", 32'(fs_cnt - fb), 32'd0);
      vsync_pulse();
      check("rst_fs_after_v2", 32'(fs_cnt - fb), 32'd1);
      send_pixels(2, 8'h80);
      end_line();
      check("rst_active_count", 32'(pd_q.size() - pb), 32'd2);
      if (pd_q.size() - pb >= 1)
         check("rst_active_p0", 32'(pd_q[pb]), 32'h8081);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
